// File: rtl/sram_readback_ctrl.sv
// Reader-side SRAM sequencer: on start it issues a burst of reads to one
// kernel/weight SRAM port and returns the words, in order, on a valid/ready
// stream. The write side of the SRAM is never touched (MEM_WEB held high).
// A small return FIFO of RD_LAT+1 entries absorbs the words while the
// consumer stalls.
module sram_readback_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] MEM_ADD,
  output logic              MEM_CSB,
  output logic              MEM_OEB,
  output logic              MEM_WEB,
  input  logic [DATA_W-1:0] MEM_DATA_O,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int FIFO_D = RD_LAT + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int OCC_W  = CNT_W + 1;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t              state_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    issue_left_r;
  logic [LEN_W-1:0]    word_left_r;
  logic [RD_LAT-1:0]   pipe_r;
  logic [DATA_W-1:0]   fifo_mem_r [FIFO_D];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    fifo_cnt_r;

  logic [OCC_W-1:0]    inflight_s;
  logic [OCC_W-1:0]    occ_s;
  logic                pop_s;
  logic                push_s;
  logic                issue_s;

  // Advance a FIFO pointer, wrapping at the (possibly non power of two) depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_D - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign out_valid = (fifo_cnt_r != '0);
  assign out_data  = fifo_mem_r[rd_ptr_r];
  assign pop_s     = out_valid && out_ready;
  assign push_s    = pipe_r[RD_LAT-1];
  assign busy      = busy_r;
  assign done      = done_r;

  // Count reads that have left the address port but not yet landed in the FIFO.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_r[i]) begin
        inflight_s = inflight_s + OCC_W'(1);
      end else begin
        inflight_s = inflight_s;
      end
    end
  end

  // Slots committed after this cycle's pop; the word leaving this cycle frees
  // its slot for a new read, which is what sustains one word per cycle with a
  // FIFO only RD_LAT+1 deep.
  always_comb begin
    if (pop_s) begin
      occ_s = OCC_W'(fifo_cnt_r) + inflight_s - OCC_W'(1);
    end else begin
      occ_s = OCC_W'(fifo_cnt_r) + inflight_s;
    end
  end

  assign issue_s = (state_r == READ) && (issue_left_r != '0) &&
                   (occ_s < OCC_W'(FIFO_D));

  // The issue decision depends on this cycle's pop, so the SRAM strobes are
  // decoded from it; the address itself is the held address register.
  assign MEM_CSB = ~issue_s;
  assign MEM_OEB = ~issue_s;
  assign MEM_WEB = 1'b1;
  assign MEM_ADD = addr_r;

  // In-flight read tracker: one valid bit per SRAM latency stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_r <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      pipe_r[0] <= issue_s;
    end
  end

  // Return FIFO: captures SRAM data as reads complete, supports push+pop together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= MEM_DATA_O;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Burst sequencer: command accept, address walk, drain and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      addr_r       <= '0;
      issue_left_r <= '0;
      word_left_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r       <= base_addr;
            issue_left_r <= count;
            word_left_r  <= count;
            if (count == '0) begin
              state_r <= FIN;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= READ;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        READ: begin
          if (pop_s) begin
            word_left_r <= word_left_r - LEN_W'(1);
          end else begin
            word_left_r <= word_left_r;
          end
          if (issue_s) begin
            addr_r       <= addr_r + ADDR_W'(1);
            issue_left_r <= issue_left_r - LEN_W'(1);
            if (issue_left_r == LEN_W'(1)) begin
              state_r <= DRAIN;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= READ;
          end
        end
        DRAIN: begin
          if (pop_s) begin
            word_left_r <= word_left_r - LEN_W'(1);
            if (word_left_r == LEN_W'(1)) begin
              state_r <= FIN;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= DRAIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_readback_ctrl.md
Name: sram_readback_ctrl

Overview:
Reader-side SRAM sequencer: on a start command it issues a burst of reads to one kernel/weight SRAM port using the active-low CSB/OEB/WEB convention. It returns the words in order on a valid/ready stream. It sits beside the learn/classify datapath and gives the bench or host a path to dump memory contents loaded through the write side. It never writes: WEB is held high at all times.

Parameters:
ADDR_W, 5, SRAM address width (depth 2^ADDR_W words)
DATA_W, 32, SRAM word width
RD_LAT, 1, SRAM read latency in cycles from address-sampling edge to data capture; legal values 1 or 2
FIFO_D, RD_LAT+1, return buffer depth (derived, not overridden)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  launch burst; sampled only when busy=0
base_addr  in  ADDR_W  first address of burst
count  in  ADDR_W+1  number of words, 0..2^ADDR_W
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
MEM_ADD  out  ADDR_W  SRAM address
MEM_CSB  out  1  chip select, active low
MEM_OEB  out  1  output enable, active low
MEM_WEB  out  1  write enable, active low; constant 1
MEM_DATA_O  in  DATA_W  SRAM read data
out_data  out  DATA_W  returned word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when valid&&ready

Behaviour:
- Reset (sync, any state, including mid-burst):
  - state=IDLE; busy=0; done=0; out_valid=0; out_data=0; MEM_ADD=0; MEM_CSB=1; MEM_OEB=1; MEM_WEB=1.
  - FIFO flushed; in-flight reads discarded.
- States:
  - IDLE -> READ on start with count>0.
  - IDLE -> FIN on start with count=0.
  - READ -> DRAIN after the last address is issued.
  - DRAIN -> FIN when the last word is accepted.
  - FIN -> IDLE unconditionally, after one cycle.
- busy=1 in READ and DRAIN.
- done=1 only in FIN, so the pulse is one cycle. busy=0 in FIN.
- start while busy=1 or in FIN: ignored. base_addr and count are latched only at accept.
- Issue rule, per READ cycle:
  - Drive MEM_CSB=0, MEM_OEB=0, MEM_ADD=current address only if (fifo_count + inflight) < FIFO_D, and not all addresses have been issued.
  - Otherwise drive MEM_CSB=1, MEM_OEB=1, MEM_ADD holds.
  - Never overflow the FIFO; no word is dropped or duplicated.
- Address increments by 1 per issued read, modulo 2^ADDR_W (wrap 31->0 for ADDR_W=5).
- Capture: a read issued in cycle n is captured from MEM_DATA_O at the end of cycle n+RD_LAT and is visible on out_data/out_valid in cycle n+RD_LAT+1. A per-stage valid shift register of length RD_LAT tracks in-flight reads.
- Latency (RD_LAT=1, out_ready=1):
  - start in cycle 0 -> first address in cycle 1 -> first out_valid in cycle 3.
  - Then 1 word/cycle.
  - Last word for count=N in cycle N+2; done in cycle N+3.
- Stream rules:
  - out_valid and out_data stay stable until accepted.
  - FIFO supports a simultaneous push and pop in the same cycle.
  - out_ready may toggle arbitrarily.
- count=2^ADDR_W reads the whole memory once, starting at base_addr with wrap.
- IDLE and FIN: MEM_CSB=1, MEM_OEB=1.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle 5 cycles -> all outputs at reset values, MEM_CSB/OEB/WEB=1 throughout.
- Basic burst: model SRAM mem[i]=32'h100+i, RD_LAT=1, start base=3 count=4, out_ready=1:
  - MEM_ADD=3,4,5,6 in cycles 1-4 with CSB=0.
  - out_data 0x103..0x106 in cycles 3-6.
  - done pulse in cycle 7, busy low in cycle 7.
- Wrap: base=30 count=4 -> addresses 30,31,0,1; data 0x11E,0x11F,0x100,0x101.
- Backpressure:
  - base=0 count=6, out_ready alternating 1/0 and then held 0 for 4 cycles.
  - Exactly 6 words, values 0x100..0x105, in order.
  - CSB stays high while the FIFO plus in-flight reads equal FIFO_D.
  - out_data is stable while stalled.
- Edge commands:
  - count=0 -> no CSB low, done pulses in cycle 1.
  - A second start while busy is ignored; only the first burst's words appear.
- Reset mid-burst: assert rst in the cycle after the 2nd word is accepted (count=8):
  - Next cycle shows busy=0, out_valid=0, CSB=1, no done.
  - A new start base=0 count=2 returns 0x100, 0x101 only.
